// File: rtl/packet_dispatcher.sv
// Packet dispatcher: buffers ingress headers in a small FIFO and hands them one at a time to
// an external classifier, then holds each classification result until the consumer takes it.
// Optional build macro DISPATCH_TIMEOUT_EN adds a classifier wait limit of TIMEOUT_CYCLES.
module packet_dispatcher #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [103:0] in_hdr,
  output logic         cls_input_is_valid,
  output logic [103:0] cls_hdr,
  input  logic         cls_ready_to_process,
  input  logic [103:0] cls_first,
  input  logic [103:0] cls_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [103:0] out_hdr,
  output logic [103:0] out_first,
  output logic [103:0] out_last,
  output logic [7:0]   out_seq,
  output logic         out_timeout
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT_CYCLES < 4) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 4");
  end

  typedef enum logic [2:0] {StIdle, StIssue, StWaitAck, StWaitDone, StHold} state_e;

  state_e              state_q, state_d;
  logic [103:0]        fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [103:0]        cls_hdr_q, cls_hdr_d;
  logic [7:0]          seq_cnt_q, seq_cnt_d, cur_seq_q, cur_seq_d;
  logic                out_valid_q, out_valid_d;
  logic [103:0]        out_hdr_q, out_hdr_d, out_first_q, out_first_d, out_last_q, out_last_d;
  logic [7:0]          out_seq_q, out_seq_d;
  logic                push, issue_go, done_go, abort_go, tmo_hit;

  assign in_ready  = (fifo_cnt_q != CntW'(FIFO_DEPTH));
  assign push      = in_valid && in_ready;
  // Issue only when nothing is outstanding downstream, so at most one header is in flight.
  assign issue_go  = (state_q == StIdle) && (fifo_cnt_q != '0) && cls_ready_to_process &&
                     !out_valid_q;
  assign done_go   = (state_q == StWaitDone) && cls_ready_to_process;
  // A real completion in the same cycle as the limit wins over the abort.
  assign abort_go  = tmo_hit && !done_go;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            in_wait;
  logic            out_timeout_q, out_timeout_d;

  assign in_wait = (state_q == StWaitAck) || (state_q == StWaitDone);
  // Limit reached on the TIMEOUT_CYCLES-th cycle spent waiting on the classifier.
  assign tmo_hit = in_wait && (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

  // Wait counter: runs across both wait states, cleared everywhere else.
  always_comb begin
    tmo_cnt_d     = in_wait ? tmo_cnt_q + TmoW'(1) : '0;
    out_timeout_d = out_timeout_q;
    if (done_go || abort_go) out_timeout_d = abort_go;
  end

  // Timeout state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q     <= '0;
      out_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      out_timeout_q <= out_timeout_d;
    end
  end

  assign out_timeout = out_timeout_q;
`else
  assign tmo_hit     = 1'b0;
  assign out_timeout = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (issue_go) state_d = StIssue;
      StIssue:    state_d = StWaitAck;
      StWaitAck:  if (abort_go) state_d = StHold;
                  else if (!cls_ready_to_process) state_d = StWaitDone;
      StWaitDone: if (done_go || abort_go) state_d = StHold;
      StHold:     if (out_valid_q && out_ready) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    cls_input_is_valid = (state_q == StIssue);
  end

  // Datapath next state: FIFO pointers, issued header, sequence numbers and result capture.
  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d    = issue_go ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q;
    unique case ({push, issue_go})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CntW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CntW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    cls_hdr_d   = issue_go ? fifo_mem_q[rd_ptr_q] : cls_hdr_q;
    seq_cnt_d   = seq_cnt_q + {7'd0, issue_go};
    cur_seq_d   = issue_go ? seq_cnt_q : cur_seq_q;
    out_valid_d = out_valid_q;
    out_hdr_d   = out_hdr_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    out_seq_d   = out_seq_q;
    if (done_go || abort_go) begin
      out_valid_d = 1'b1;
      out_hdr_d   = cls_hdr_q;
      out_first_d = done_go ? cls_first : '0;
      out_last_d  = done_go ? cls_last : '0;
      out_seq_d   = cur_seq_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // FIFO storage; contents need no reset since the count gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= in_hdr;
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      cls_hdr_q   <= '0;
      seq_cnt_q   <= '0;
      cur_seq_q   <= '0;
      out_valid_q <= 1'b0;
      out_hdr_q   <= '0;
      out_first_q <= '0;
      out_last_q  <= '0;
      out_seq_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      cls_hdr_q   <= cls_hdr_d;
      seq_cnt_q   <= seq_cnt_d;
      cur_seq_q   <= cur_seq_d;
      out_valid_q <= out_valid_d;
      out_hdr_q   <= out_hdr_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_seq_q   <= out_seq_d;
    end
  end

  assign cls_hdr   = cls_hdr_q;
  assign out_valid = out_valid_q;
  assign out_hdr   = out_hdr_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign out_seq   = out_seq_q;

endmodule

// File: tb/tb_packet_dispatcher.sv
// Bench for packet_dispatcher: behavioural classifier, ingress driver and result scoreboard.
module tb_packet_dispatcher;

  localparam int unsigned Depth = 4;
  localparam int unsigned Tmo   = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [103:0] in_hdr = '0;
  logic         cls_input_is_valid;
  logic [103:0] cls_hdr;
  logic         cls_ready_to_process = 1'b1;
  logic [103:0] cls_first = '0;
  logic [103:0] cls_last = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [103:0] out_hdr, out_first, out_last;
  logic [7:0]   out_seq;
  logic         out_timeout;

  packet_dispatcher #(
    .FIFO_DEPTH     (Depth),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_hdr               (in_hdr),
    .cls_input_is_valid   (cls_input_is_valid),
    .cls_hdr              (cls_hdr),
    .cls_ready_to_process (cls_ready_to_process),
    .cls_first            (cls_first),
    .cls_last             (cls_last),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_hdr              (out_hdr),
    .out_first            (out_first),
    .out_last             (out_last),
    .out_seq              (out_seq),
    .out_timeout          (out_timeout)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard entries are {seq, hdr}.
  logic [111:0] sb_q[$];
  logic [7:0]   sb_seq = 8'd0;
  logic [7:0]   last_seq;

  // Classifier model controls and observations.
  int  cls_lat = 3;
  bit  cls_stall = 1'b0;
  bit  cls_never = 1'b0;
  int  issue_cnt = 0;
  int  pulse_err = 0;
  int  hdr_err = 0;
  bit  gap_en = 1'b0;
  int  last_issue_cyc = -1;
  int  min_gap = 1000;

  function automatic logic [103:0] model_first(input logic [103:0] h);
    return h ^ {13{8'hA5}};
  endfunction

  function automatic logic [103:0] model_last(input logic [103:0] h);
    return ~h;
  endfunction

  function automatic logic [103:0] rand_hdr();
    return {$urandom(), $urandom(), 16'($urandom()), 16'($urandom()), 8'($urandom())};
  endfunction

  // Behavioural classifier: drops ready on an issue, raises it cls_lat cycles later.
  initial begin
    logic [103:0] cur;
    int cnt;
    bit busy;
    bit prev_issue;
    cur = '0; cnt = 0; busy = 1'b0; prev_issue = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 1'b0;
        prev_issue = 1'b0;
        cls_ready_to_process = !cls_stall;
      end else begin
        if (cls_input_is_valid) begin
          issue_cnt++;
          if (prev_issue) pulse_err++;
          if (gap_en && last_issue_cyc >= 0 && (cyc - last_issue_cyc) < min_gap)
            min_gap = cyc - last_issue_cyc;
          last_issue_cyc = cyc;
          cur = cls_hdr;
          cnt = cls_lat;
          busy = 1'b1;
          cls_ready_to_process = 1'b0;
        end else if (busy) begin
          if (cls_hdr !== cur) hdr_err++;
          if (cnt > 1) cnt--;
          else if (!cls_never) begin
            busy = 1'b0;
            cls_first = model_first(cur);
            cls_last = model_last(cur);
            cls_ready_to_process = 1'b1;
          end
        end else begin
          cls_ready_to_process = !cls_stall;
        end
        prev_issue = cls_input_is_valid;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    sb_seq = 8'd0;
  endtask

  task automatic push_hdr(input logic [103:0] h);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_hdr = h;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL push_wait in_ready=%b want=1", in_ready);
    end else begin
      sb_q.push_back({sb_seq, h});
      sb_seq++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input bit exp_tmo, input bit keep_ready);
    int n = 0;
    logic [111:0] e;
    logic [103:0] eh;
    while (out_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL collect_wait out_valid=%b want=1", out_valid);
      return;
    end
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL sb_empty got result hdr=%h want none", out_hdr);
    end else begin
      e = sb_q.pop_front();
      eh = e[103:0];
      total += 4;
      if (out_hdr !== eh) begin
        bad++;
        $display("FAIL out_hdr got=%h want=%h", out_hdr, eh);
      end
      if (out_first !== (exp_tmo ? 104'd0 : model_first(eh))) begin
        bad++;
        $display("FAIL out_first got=%h want=%h", out_first,
                 exp_tmo ? 104'd0 : model_first(eh));
      end
      if (out_last !== (exp_tmo ? 104'd0 : model_last(eh))) begin
        bad++;
        $display("FAIL out_last got=%h want=%h", out_last, exp_tmo ? 104'd0 : model_last(eh));
      end
      if (out_seq !== e[111:104]) begin
        bad++;
        $display("FAIL out_seq got=%0d want=%0d", out_seq, e[111:104]);
      end
      last_seq = out_seq;
    end
    total++;
    if (out_timeout !== exp_tmo) begin
      bad++;
      $display("FAIL out_timeout got=%b want=%b", out_timeout, exp_tmo);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = keep_ready;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    total += 4;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    if ({cls_input_is_valid, cls_hdr} !== 105'd0) begin
      bad++;
      $display("FAIL reset_cls got=%b/%h want=0/0", cls_input_is_valid, cls_hdr);
    end
    if ({out_valid, out_timeout, out_seq} !== 10'd0) begin
      bad++;
      $display("FAIL reset_out_ctl got=%b/%b/%0d want=0/0/0", out_valid, out_timeout, out_seq);
    end
    if ({out_hdr, out_first, out_last} !== 312'd0) begin
      bad++;
      $display("FAIL reset_out_data got=%h/%h/%h want=0", out_hdr, out_first, out_last);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    int i0;
    cls_lat = 3;
    i0 = issue_cnt;
    push_hdr({32'h0A000001, 32'h0A000002, 16'h0050, 16'h1F90, 8'h06});
    collect(1'b0, 1'b0);
    total += 3;
    if (issue_cnt - i0 !== 1) begin
      bad++;
      $display("FAIL single_issue_count got=%0d want=1", issue_cnt - i0);
    end
    if (pulse_err !== 0) begin
      bad++;
      $display("FAIL single_pulse_width got=%0d long pulses want=0", pulse_err);
    end
    if (hdr_err !== 0) begin
      bad++;
      $display("FAIL single_cls_hdr_stable got=%0d changes want=0", hdr_err);
    end
  endtask

  task automatic test_fifo_full();
    logic [103:0] h5;
    int i0;
    do_reset();
    cls_stall = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) push_hdr(rand_hdr());
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_in_ready got=%b want=0", in_ready);
    end
    i0 = issue_cnt;
    h5 = rand_hdr();
    @(negedge clk);
    in_valid = 1'b1;
    in_hdr = h5;
    repeat (3) @(negedge clk);
    total += 2;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_hold_in_ready got=%b want=0", in_ready);
    end
    if (issue_cnt !== i0) begin
      bad++;
      $display("FAIL full_stalled_issue got=%0d want=%0d", issue_cnt, i0);
    end
    cls_stall = 1'b0;
    push_hdr(h5);
    for (int k = 0; k < 5; k++) collect(1'b0, 1'b0);
  endtask

  task automatic test_hold();
    int n = 0;
    int i0;
    logic [111:0] e;
    push_hdr(rand_hdr());
    push_hdr(rand_hdr());
    while (out_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    i0 = issue_cnt;
    e = sb_q[0];
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_hdr, out_first, out_last, out_seq} !==
          {1'b1, e[103:0], model_first(e[103:0]), model_last(e[103:0]), e[111:104]}) begin
        bad++;
        $display("FAIL hold_stable cycle=%0d got v=%b hdr=%h seq=%0d want v=1 hdr=%h seq=%0d",
                 k, out_valid, out_hdr, out_seq, e[103:0], e[111:104]);
      end
    end
    total++;
    if (issue_cnt !== i0) begin
      bad++;
      $display("FAIL hold_no_issue got=%0d want=%0d", issue_cnt, i0);
    end
    collect(1'b0, 1'b0);
    collect(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int hits = 0;
    cls_never = 1'b1;
    push_hdr(rand_hdr());
    while (cls_input_is_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    total += 3;
    if ({out_valid, out_seq, out_timeout} !== 10'd0) begin
      bad++;
      $display("FAIL midreset_out got=%b/%0d/%b want=0/0/0", out_valid, out_seq, out_timeout);
    end
    if ({cls_input_is_valid, cls_hdr} !== 105'd0) begin
      bad++;
      $display("FAIL midreset_cls got=%b/%h want=0/0", cls_input_is_valid, cls_hdr);
    end
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_in_ready got=%b want=1", in_ready);
    end
    sb_q.delete();
    sb_seq = 8'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cls_never = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) hits++;
    end
    total++;
    if (hits !== 0) begin
      bad++;
      $display("FAIL midreset_no_result got=%0d valid cycles want=0", hits);
    end
    push_hdr(rand_hdr());
    collect(1'b0, 1'b0);
  endtask

  task automatic test_timeout();
`ifdef DISPATCH_TIMEOUT_EN
    int n = 0;
    int c0;
    do_reset();
    cls_never = 1'b1;
    push_hdr(rand_hdr());
    while (cls_input_is_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    c0 = cyc;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (cyc - c0 !== 9) begin
      bad++;
      $display("FAIL timeout_latency got=%0d want=9 cycles after issue", cyc - c0);
    end
    collect(1'b1, 1'b0);
    cls_never = 1'b0;
    do_reset();
`else
    // Without the wait limit a silent classifier must never produce a result.
    int hits = 0;
    do_reset();
    cls_never = 1'b1;
    push_hdr(rand_hdr());
    for (int k = 0; k < 3 * Tmo; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) hits++;
    end
    total++;
    if (hits !== 0) begin
      bad++;
      $display("FAIL no_timeout_result got=%0d valid cycles want=0", hits);
    end
    cls_never = 1'b0;
    do_reset();
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    cls_lat = 2;
    out_ready = 1'b1;
    gap_en = 1'b1;
    min_gap = 1000;
    last_issue_cyc = -1;
    fork
      for (int k = 0; k < 257; k++) push_hdr(rand_hdr());
      for (int k = 0; k < 257; k++) collect(1'b0, 1'b1);
    join
    gap_en = 1'b0;
    out_ready = 1'b0;
    total += 2;
    if (min_gap !== 5) begin
      bad++;
      $display("FAIL issue_spacing got=%0d want=5", min_gap);
    end
    if (last_seq !== 8'd0) begin
      bad++;
      $display("FAIL seq_wrap got=%0d want=0", last_seq);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fifo_full();
    test_hold();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
